// File: rtl/main_decoder.sv
// Main control decoder: turns Op/Funct5/Funct1 into registered datapath controls.
// Optional MAIN_DECODER_ILLEGAL_EN adds a registered Illegal flag for Op = 11.
module main_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic       Funct5,
  input  logic       Funct1,
  output logic       Branch,
  output logic       RegW,
  output logic       MemW,
  output logic       MemtoReg,
  output logic       ALUSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
`ifdef MAIN_DECODER_ILLEGAL_EN
  output logic       ALUOp,
  output logic       Illegal
`else
  output logic       ALUOp
`endif
);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  logic       branch_d;
  logic       regw_d;
  logic       memw_d;
  logic       memtoreg_d;
  logic       alusrc_d;
  logic [1:0] immsrc_d;
  logic [1:0] regsrc_d;
  logic       aluop_d;

  // Unlisted/don't-care fields stay 0 so Op = 11 decodes as a harmless NOP.
  always_comb begin
    branch_d   = 1'b0;
    regw_d     = 1'b0;
    memw_d     = 1'b0;
    memtoreg_d = 1'b0;
    alusrc_d   = 1'b0;
    immsrc_d   = 2'b00;
    regsrc_d   = 2'b00;
    aluop_d    = 1'b0;
    case (Op)
      OP_DP: begin
        regw_d   = 1'b1;
        alusrc_d = Funct5;
        aluop_d  = 1'b1;
      end
      OP_MEM: begin
        alusrc_d = 1'b1;
        immsrc_d = 2'b01;
        if (Funct1) begin
          regw_d     = 1'b1;
          memtoreg_d = 1'b1;
        end else begin
          memw_d   = 1'b1;
          regsrc_d = 2'b10;
        end
      end
      OP_BR: begin
        branch_d = 1'b1;
        alusrc_d = 1'b1;
        immsrc_d = 2'b10;
        regsrc_d = 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Branch   <= 1'b0;
      RegW     <= 1'b0;
      MemW     <= 1'b0;
      MemtoReg <= 1'b0;
      ALUSrc   <= 1'b0;
      ImmSrc   <= 2'b00;
      RegSrc   <= 2'b00;
      ALUOp    <= 1'b0;
    end else begin
      Branch   <= branch_d;
      RegW     <= regw_d;
      MemW     <= memw_d;
      MemtoReg <= memtoreg_d;
      ALUSrc   <= alusrc_d;
      ImmSrc   <= immsrc_d;
      RegSrc   <= regsrc_d;
      ALUOp    <= aluop_d;
    end
  end

`ifdef MAIN_DECODER_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (rst) Illegal <= 1'b0;
    else     Illegal <= (Op == 2'b11);
  end
`endif

endmodule

// File: tb/tb_main_decoder.sv
// Randomized and directed bench for main_decoder against a table-driven reference.
// Build with MAIN_DECODER_ILLEGAL_EN to also check the Illegal output.
module tb_main_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] Op;
  logic       Funct5;
  logic       Funct1;
  logic       Branch, RegW, MemW, MemtoReg, ALUSrc, ALUOp;
  logic [1:0] ImmSrc, RegSrc;
`ifdef MAIN_DECODER_ILLEGAL_EN
  logic       Illegal;
`endif

  int checks   = 0;
  int failures = 0;

  // Rows: Branch RegW MemW MemtoReg ALUSrc ImmSrc RegSrc ALUOp
  logic [10:0] table_rows [6];

  always #5 clk = ~clk;

  main_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .Op       (Op),
    .Funct5   (Funct5),
    .Funct1   (Funct1),
    .Branch   (Branch),
    .RegW     (RegW),
    .MemW     (MemW),
    .MemtoReg (MemtoReg),
    .ALUSrc   (ALUSrc),
    .ImmSrc   (ImmSrc),
    .RegSrc   (RegSrc),
`ifdef MAIN_DECODER_ILLEGAL_EN
    .ALUOp    (ALUOp),
    .Illegal  (Illegal)
`else
    .ALUOp    (ALUOp)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model(input logic r, input logic [1:0] op, input logic f5, input logic f1);
    int idx;
    if (r) return 11'd0;
    if (op == 2'd0)      idx = int'(f5);
    else if (op == 2'd1) idx = 2 + int'(f1);
    else if (op == 2'd2) idx = 4;
    else                 idx = 5;
    return table_rows[idx];
  endfunction

  function automatic logic [10:0] observed();
    return {Branch, RegW, MemW, MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUOp};
  endfunction

  // Apply inputs, take one edge, compare; then wiggle inputs between edges and confirm hold.
  task automatic step(input string tag, input logic r, input logic [1:0] op,
                      input logic f5, input logic f1, input bit wiggle);
    logic [10:0] exp;
    rst = r; Op = op; Funct5 = f5; Funct1 = f1;
    exp = model(r, op, f5, f1);
    @(posedge clk);
    #1;
    check(tag, 32'(observed()), 32'(exp));
    check({tag, "_regw_memw"}, 32'(RegW & MemW), 32'd0);
`ifdef MAIN_DECODER_ILLEGAL_EN
    check({tag, "_illegal"}, 32'(Illegal), 32'(!r && op == 2'b11));
`endif
    if (wiggle) begin
      Op = 2'($urandom); Funct5 = 1'($urandom); Funct1 = 1'($urandom);
      #2;
      check({tag, "_hold"}, 32'(observed()), 32'(exp));
    end
  endtask

  initial begin
    logic [3:0] combo;
    table_rows[0] = 11'b0_1_0_0_0_00_00_1;
    table_rows[1] = 11'b0_1_0_0_1_00_00_1;
    table_rows[2] = 11'b0_0_1_0_1_01_10_0;
    table_rows[3] = 11'b0_1_0_1_1_01_00_0;
    table_rows[4] = 11'b1_0_0_0_1_10_01_0;
    table_rows[5] = 11'b0_0_0_0_0_00_00_0;

    rst = 1'b1; Op = 2'b00; Funct5 = 1'b1; Funct1 = 1'b0;
    #2;

    step("reset", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    step("reset2", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    step("release_dp_imm", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("release_fields", 32'({RegW, ALUSrc, ALUOp, Branch, MemW}), 32'b11100);

    step("dp_reg", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("dp_reg_alusrc", 32'(ALUSrc), 32'd0);
    step("dp_imm", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    check("dp_imm_alusrc", 32'(ALUSrc), 32'd1);

    step("str", 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
    check("str_fields", 32'({MemW, RegW, ImmSrc, RegSrc}), 32'b10_01_10);
    step("ldr", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    check("ldr_fields", 32'({MemW, RegW, MemtoReg, RegSrc}), 32'b011_00);

    for (int i = 0; i < 4; i++) begin
      step("branch", 1'b0, 2'b10, 1'(i >> 1), 1'(i), 1'b1);
      check("branch_fields", 32'({Branch, ALUSrc, ImmSrc, RegSrc, RegW, MemW}), 32'b11_10_01_00);
    end

    step("op11", 1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    check("op11_zero", 32'(observed()), 32'd0);
    step("after_op11", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      combo = 4'(i);
      step("sweep", 1'b0, combo[3:2], combo[1], combo[0], 1'b0);
    end

    // Mid-stream reset drops the in-flight decode.
    step("pre_rst", 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    step("mid_rst", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step("post_rst", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(0, 15) == 0), 2'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
